// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and the source/destination match rule for the hazard controller.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package hazard_ctrl_pkg;

  // Two-state sequencer encoding, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_WAIT = 1'b1;

  // Exec operand source selects.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EX = 2'b10;

  // A decode source depends on an older writer when both sides are active,
  // the register numbers and the register files agree, and the register is
  // not integer r0 (FP f0 is a real register).
  function automatic logic src_match(
    input logic       use_src,
    input logic [4:0] rs,
    input logic       rs_fp,
    input logic       regwrite,
    input logic [4:0] rw,
    input logic       rw_fp
  );
    return use_src && regwrite && (rs == rw) && (rs_fp == rw_fp) &&
           (rs_fp || (rs != 5'd0));
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational source matching: exec-operand forwarding selects and load-use detect.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the parent decides whether a detected hazard stalls.
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_rs1_fp,
  input  logic       id_rs2_fp,
  input  logic [4:0] ex_rw,
  input  logic       ex_regwrite,
  input  logic       ex_mem2reg,
  input  logic       ex_wfp,
  input  logic [4:0] mem_rw,
  input  logic       mem_regwrite,
  input  logic       mem_wfp,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       load_use
);

  logic ex_hit_a;
  logic ex_hit_b;
  logic mem_hit_a;
  logic mem_hit_b;

  assign ex_hit_a  = src_match(id_use_rs1, id_rs1, id_rs1_fp, ex_regwrite, ex_rw, ex_wfp);
  assign ex_hit_b  = src_match(id_use_rs2, id_rs2, id_rs2_fp, ex_regwrite, ex_rw, ex_wfp);
  assign mem_hit_a = src_match(id_use_rs1, id_rs1, id_rs1_fp, mem_regwrite, mem_rw, mem_wfp);
  assign mem_hit_b = src_match(id_use_rs2, id_rs2, id_rs2_fp, mem_regwrite, mem_rw, mem_wfp);

  // A load in exec has no data yet, so it cannot forward; it becomes a stall.
  assign load_use = (ex_hit_a || ex_hit_b) && ex_mem2reg;

  // Exec is the younger writer and therefore wins over mem.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_hit_a && !ex_mem2reg) fwd_a = FWD_EX;
    else if (mem_hit_a)          fwd_a = FWD_WB;
    if (ex_hit_b && !ex_mem2reg) fwd_b = FWD_EX;
    else if (mem_hit_b)          fwd_b = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: hazard stalls, redirect flushes, forwarding, FP mul/div handshake.
// Latency: controls are combinational from state and inputs; counters/flags update next edge.
// Backpressure: holds the front of the pipe while a load-use or mul/div wait is pending.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_rs1_fp,
  input  logic             id_rs2_fp,
  input  logic             id_mc,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regwrite,
  input  logic             ex_mem2reg,
  input  logic             ex_wfp,
  input  logic [4:0]       mem_rw,
  input  logic             mem_regwrite,
  input  logic             mem_wfp,
  input  logic             mem_branch_taken,
  input  logic             mc_done,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mc_go,
  output logic             mc_abort,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MC_TIMEOUT - 1);

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nxt;
  logic          err_nxt;
  logic          load_use;
  logic [1:0]    fwd_a_raw;
  logic [1:0]    fwd_b_raw;

  logic pc_stall_r, ifid_stall_r, idex_stall_r, idex_bubble_r, exmem_bubble_r;
  logic flush_r, go_r, abort_r;

  hazard_fwd_unit u_fwd (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rs1_fp    (id_rs1_fp),
    .id_rs2_fp    (id_rs2_fp),
    .ex_rw        (ex_rw),
    .ex_regwrite  (ex_regwrite),
    .ex_mem2reg   (ex_mem2reg),
    .ex_wfp       (ex_wfp),
    .mem_rw       (mem_rw),
    .mem_regwrite (mem_regwrite),
    .mem_wfp      (mem_wfp),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw),
    .load_use     (load_use)
  );

  // Control decode: redirect first, then mul/div wait, then load-use / mul/div launch.
  always_comb begin
    pc_stall_r     = 1'b0;
    ifid_stall_r   = 1'b0;
    idex_stall_r   = 1'b0;
    idex_bubble_r  = 1'b0;
    exmem_bubble_r = 1'b0;
    flush_r        = 1'b0;
    go_r           = 1'b0;
    abort_r        = 1'b0;
    state_nxt      = state;
    tcnt_nxt       = tcnt;
    err_nxt        = mc_error;
    if (mem_branch_taken) begin
      // The mul/div in flight is younger than the branch, so it is killed
      // without flagging an error, even if its result arrives this cycle.
      flush_r   = 1'b1;
      abort_r   = (state == ST_MC_WAIT);
      state_nxt = ST_RUN;
      tcnt_nxt  = '0;
    end else if (state == ST_MC_WAIT) begin
      if (mc_done) begin
        state_nxt = ST_RUN;
        tcnt_nxt  = '0;
      end else begin
        // The abandoning cycle is still a wait cycle; the pipe releases next cycle.
        pc_stall_r     = 1'b1;
        ifid_stall_r   = 1'b1;
        idex_stall_r   = 1'b1;
        exmem_bubble_r = 1'b1;
        if (tcnt == T_LAST) begin
          abort_r   = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ST_RUN;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
    end else if (load_use) begin
      pc_stall_r    = 1'b1;
      ifid_stall_r  = 1'b1;
      idex_bubble_r = 1'b1;
    end else if (id_mc) begin
      go_r      = 1'b1;
      state_nxt = ST_MC_WAIT;
      tcnt_nxt  = '0;
    end
  end

  // Every combinational output is held low while reset is asserted.
  assign pc_stall     = reset & pc_stall_r;
  assign ifid_stall   = reset & ifid_stall_r;
  assign idex_stall   = reset & idex_stall_r;
  assign idex_bubble  = reset & idex_bubble_r;
  assign exmem_bubble = reset & exmem_bubble_r;
  assign flush_ifid   = reset & flush_r;
  assign flush_idex   = reset & flush_r;
  assign mc_go        = reset & go_r;
  assign mc_abort     = reset & abort_r;
  assign fwd_a        = reset ? fwd_a_raw : FWD_RF;
  assign fwd_b        = reset ? fwd_b_raw : FWD_RF;

  // Sequencer state, timeout counter and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      tcnt     <= '0;
      mc_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      tcnt     <= tcnt_nxt;
      mc_error <= err_nxt;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1))         stall_cnt <= stall_cnt + 1'b1;
      if (mem_branch_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MC_TIMEOUT = 8;
  localparam int CNT_W      = 4;
  localparam int CMAX       = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [6:0]       ctl;   // pc, ifid, idex_stall, idex_bubble, exmem_bubble, flush_ifid, flush_idex
    logic             go;
    logic             abort;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             err;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rw = '0, mem_rw = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, id_rs1_fp = 0, id_rs2_fp = 0, id_mc = 0;
  logic ex_regwrite = 0, ex_mem2reg = 0, ex_wfp = 0;
  logic mem_regwrite = 0, mem_wfp = 0, mem_branch_taken = 0, mc_done = 0;

  logic pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble;
  logic flush_ifid, flush_idex, mc_go, mc_abort, mc_error;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // reference model state
  bit m_wait = 0;
  int m_wcnt = 0;
  bit m_err  = 0;
  int m_sc   = 0;
  int m_fc   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clk), .reset(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp), .id_mc(id_mc),
    .ex_rw(ex_rw), .ex_regwrite(ex_regwrite), .ex_mem2reg(ex_mem2reg), .ex_wfp(ex_wfp),
    .mem_rw(mem_rw), .mem_regwrite(mem_regwrite), .mem_wfp(mem_wfp),
    .mem_branch_taken(mem_branch_taken), .mc_done(mc_done),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_go(mc_go), .mc_abort(mc_abort),
    .mc_error(mc_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic bit dep(bit u, int rs, bit fp, bit wr, int rw, bit wfp);
    return u && wr && rs == rw && fp == wfp && (fp || rs != 0);
  endfunction

  function automatic int sel(bit exh, bit load, bit memh);
    if (exh && !load) return 2;
    if (memh) return 1;
    return 0;
  endfunction

  // Reference: derive this cycle's expected outputs, then advance the model.
  task automatic commit();
    exp_t e;
    bit ea, eb, lu, stall4;
    e = '0;
    if (!rst) begin
      m_wait = 0; m_wcnt = 0; m_err = 0; m_sc = 0; m_fc = 0;
      q.push_back(e);
      return;
    end
    e.err = m_err;
    e.sc  = CNT_W'(m_sc);
    e.fc  = CNT_W'(m_fc);
    ea = dep(id_use_rs1, id_rs1, id_rs1_fp, ex_regwrite, ex_rw, ex_wfp);
    eb = dep(id_use_rs2, id_rs2, id_rs2_fp, ex_regwrite, ex_rw, ex_wfp);
    e.fa = 2'(sel(ea, ex_mem2reg, dep(id_use_rs1, id_rs1, id_rs1_fp, mem_regwrite, mem_rw, mem_wfp)));
    e.fb = 2'(sel(eb, ex_mem2reg, dep(id_use_rs2, id_rs2, id_rs2_fp, mem_regwrite, mem_rw, mem_wfp)));
    lu = (ea || eb) && ex_mem2reg;
    stall4 = 0;
    if (mem_branch_taken) begin
      e.ctl = 7'b0000011;
      e.abort = m_wait;
      m_wait = 0;
    end else if (m_wait) begin
      if (mc_done) m_wait = 0;
      else begin
        stall4 = 1;
        if (m_wcnt == MC_TIMEOUT - 1) begin
          e.abort = 1; m_err = 1; m_wait = 0;
        end
        m_wcnt++;
      end
    end else if (lu) begin
      e.ctl = 7'b1101000;
    end else if (id_mc) begin
      e.go = 1; m_wait = 1; m_wcnt = 0;
    end
    if (stall4) e.ctl = 7'b1110100;
    if (e.ctl[6]) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    if (mem_branch_taken) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    q.push_back(e);
  endtask

  // Next cycle: all inputs idle, reset released; caller then sets what it needs.
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1; id_rs1 = 0; id_rs2 = 0; ex_rw = 0; mem_rw = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_rs1_fp = 0; id_rs2_fp = 0; id_mc = 0;
    ex_regwrite = 0; ex_mem2reg = 0; ex_wfp = 0;
    mem_regwrite = 0; mem_wfp = 0; mem_branch_taken = 0; mc_done = 0;
  endtask

  task automatic idle();
    tick(); commit();
  endtask

  task automatic do_reset();
    tick(); rst = 0; commit();
    tick(); rst = 0; commit();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_ctrl", {pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble,
                      flush_ifid, flush_idex, mc_go, mc_abort}, {e.ctl, e.go, e.abort});
      chk("sb_fwd", {fwd_a, fwd_b}, {e.fa, e.fb});
      chk("sb_regs", {mc_error, stall_cnt, flush_cnt}, {e.err, e.sc, e.fc});
    end
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_mc_error", mc_error, 0);
    chk("reset_pc_stall", pc_stall, 0);

    // exec ALU result forwards; r0 never does
    tick(); ex_rw = 5; ex_regwrite = 1; id_rs1 = 5; id_use_rs1 = 1; commit();
    @(negedge clk); chk("fwd_ex_r5", fwd_a, 2); chk("fwd_ex_nostall", pc_stall, 0);
    tick(); ex_rw = 0; ex_regwrite = 1; id_rs1 = 0; id_use_rs1 = 1; commit();
    @(negedge clk); chk("fwd_r0", fwd_a, 0);

    // load-use on rs2, then forward from mem
    tick(); ex_rw = 7; ex_regwrite = 1; ex_mem2reg = 1; id_rs2 = 7; id_use_rs2 = 1; commit();
    @(negedge clk);
    chk("lu_stalls", {pc_stall, ifid_stall, idex_bubble, idex_stall}, 4'b1110);
    tick(); mem_rw = 7; mem_regwrite = 1; id_rs2 = 7; id_use_rs2 = 1; commit();
    @(negedge clk);
    chk("lu_fwd_wb", fwd_b, 1); chk("lu_released", pc_stall, 0); chk("lu_stall_cnt", stall_cnt, 1);

    // FP f3 vs integer r3: no dependency
    tick(); ex_rw = 3; ex_regwrite = 1; ex_wfp = 1; id_rs1 = 3; id_use_rs1 = 1; commit();
    @(negedge clk); chk("fp_class_fwd", fwd_a, 0); chk("fp_class_stall", pc_stall, 0);

    // mul/div: done after five wait cycles
    do_reset();
    tick(); id_mc = 1; commit();
    @(negedge clk); chk("mc_go", mc_go, 1);
    for (int i = 0; i < 5; i++) begin
      idle(); @(negedge clk); chk("mc_wait_stall", {idex_stall, exmem_bubble}, 2'b11);
    end
    tick(); mc_done = 1; commit();
    @(negedge clk); chk("mc_done_release", pc_stall, 0);
    idle(); @(negedge clk); chk("mc_stall_cnt", stall_cnt, 5); chk("mc_back_run", pc_stall, 0);

    // timeout: abort in the 8th wait cycle, sticky error
    do_reset();
    tick(); id_mc = 1; commit();
    for (int i = 1; i <= MC_TIMEOUT; i++) begin
      idle(); @(negedge clk); chk("to_abort", mc_abort, (i == MC_TIMEOUT) ? 1 : 0);
    end
    idle(); @(negedge clk); chk("to_error", mc_error, 1); chk("to_run", pc_stall, 0);
    repeat (3) idle();
    @(negedge clk); chk("to_error_sticky", mc_error, 1);

    // redirect colliding with mc_done
    do_reset();
    tick(); id_mc = 1; commit();
    idle(); idle();
    tick(); mc_done = 1; mem_branch_taken = 1; commit();
    @(negedge clk);
    chk("br_flush", {flush_ifid, flush_idex, mc_abort, pc_stall}, 4'b1110);
    idle(); @(negedge clk);
    chk("br_no_error", mc_error, 0); chk("br_flush_cnt", flush_cnt, 1); chk("br_run", pc_stall, 0);

    // load-use together with a redirect: flush only
    tick(); ex_rw = 9; ex_regwrite = 1; ex_mem2reg = 1; id_rs1 = 9; id_use_rs1 = 1;
    mem_branch_taken = 1; commit();
    @(negedge clk); chk("lu_br", {pc_stall, idex_bubble, flush_ifid}, 3'b001);

    // reset in the middle of a wait: no abort pulse
    tick(); id_mc = 1; commit();
    idle();
    tick(); rst = 0; commit();
    @(negedge clk); chk("rst_wait_abort", {mc_abort, pc_stall}, 2'b00);

    // flush counter saturation
    for (int i = 0; i < CMAX + 4; i++) begin
      tick(); mem_branch_taken = 1; commit();
    end
    idle(); @(negedge clk); chk("flush_sat", flush_cnt, CMAX);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      tick();
      rst = ($urandom_range(0, 199) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rw = 5'($urandom_range(0, 3)); mem_rw = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_rs1_fp = ($urandom_range(0, 3) == 0); id_rs2_fp = ($urandom_range(0, 3) == 0);
      ex_wfp = ($urandom_range(0, 3) == 0); mem_wfp = ($urandom_range(0, 3) == 0);
      ex_regwrite = 1'($urandom); mem_regwrite = 1'($urandom);
      ex_mem2reg = ($urandom_range(0, 2) == 0);
      id_mc = ($urandom_range(0, 4) == 0);
      mc_done = ($urandom_range(0, 9) == 0);
      mem_branch_taken = ($urandom_range(0, 14) == 0);
      commit();
    end

    idle(); idle();
    repeat (2) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central sequencer for the five-stage integer/FP pipeline (IFU, decode, exec, mem, write).
- Detects load-use and register-source hazards and produces operand forwarding selects for exec.
- Issues stall and flush controls to the pipeline registers.
- Runs the start/done handshake for the multi-cycle FP mul/div unit, with timeout and abort.

Parameters:
MC_TIMEOUT, 64, max cycles waited for mc_done before abandoning the op
CNT_W, 16, width of the saturating performance counters

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs1  in  5  decode-stage source register 1
id_rs2  in  5  decode-stage source register 2
id_use_rs1  in  1  decode instruction reads rs1
id_use_rs2  in  1  decode instruction reads rs2
id_rs1_fp  in  1  rs1 is an FP register
id_rs2_fp  in  1  rs2 is an FP register
id_mc  in  1  decode instruction is FP mul/div
ex_rw  in  5  exec-stage destination
ex_regwrite  in  1  exec instruction writes a register
ex_mem2reg  in  1  exec instruction is a load
ex_wfp  in  1  exec destination is FP
mem_rw  in  5  mem-stage destination
mem_regwrite  in  1  mem instruction writes a register
mem_wfp  in  1  mem destination is FP
mem_branch_taken  in  1  branch/jump redirect resolved in mem
mc_done  in  1  multi-cycle unit result valid, one-cycle pulse
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
idex_stall  out  1  hold ID/EX register
idex_bubble  out  1  load NOP into ID/EX
exmem_bubble  out  1  load NOP into EX/MEM
flush_ifid  out  1  squash IF/ID
flush_idex  out  1  squash ID/EX
fwd_a  out  2  exec operand A select
fwd_b  out  2  exec operand B select
mc_go  out  1  one-cycle start pulse to multi-cycle unit
mc_abort  out  1  one-cycle kill pulse to multi-cycle unit
mc_error  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles with pc_stall high, saturating
flush_cnt  out  CNT_W  taken redirects, saturating

Behaviour:
- Reset (reset low, asynchronous):
  - State = RUN.
  - mc_error = 0; stall_cnt = 0; flush_cnt = 0; timeout counter = 0.
  - All combinational outputs forced to 0.
- Control outputs are combinational from the registered state and the current inputs.
- The FSM, counters and mc_error are registered.
- Match rule: a source matches a stage when use = 1, regwrite = 1, register numbers are equal, the FP class bits are equal, and the register is nonzero. FP register 0 is a real register, so the nonzero requirement applies to integer r0 only.
- Forwarding, fwd_a for rs1 (fwd_b identical for rs2):
  - 2'b10 if the source matches exec and ex_mem2reg = 0.
  - Otherwise 2'b01 if the source matches mem.
  - Otherwise 2'b00 (register file).
  - Exec has priority over mem.
- RUN state:
  - Load-use: a source matches exec with ex_mem2reg = 1. Assert pc_stall, ifid_stall and idex_bubble for exactly one cycle; the next cycle forwards from mem (01).
  - id_mc = 1 with no load-use: assert mc_go for one cycle as the op advances to exec, then go to MC_WAIT.
- MC_WAIT state:
  - Assert pc_stall, ifid_stall, idex_stall and exmem_bubble.
  - Timeout counter increments each cycle.
  - mc_done: return to RUN the same cycle (stalls drop) and clear the counter.
  - Counter reaches MC_TIMEOUT-1 without mc_done: set mc_error, pulse mc_abort, go to RUN.
- Branch redirect (mem_branch_taken = 1) has top priority in every state:
  - Assert flush_ifid and flush_idex; suppress all stalls and mc_go that cycle.
  - In MC_WAIT: also pulse mc_abort and go to RUN (the mul/div is younger than the branch). mc_error is not set.
- Simultaneous mc_done and mem_branch_taken: the branch wins, and mc_abort is still pulsed.
- Load-use and redirect in the same cycle: flush only, no stall.
- Counters saturate at all-ones and never wrap.
  - stall_cnt increments on every cycle with pc_stall = 1.
  - flush_cnt increments on every cycle with mem_branch_taken = 1.
- mc_error clears only on reset.
- Reset asserted mid-MC_WAIT: immediate return to RUN with no mc_abort pulse. The mul/div unit shares the same reset.

Decomposition:
- Shared package:
  - FSM state encoding (RUN, MC_WAIT).
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_EX = 2'b10.
- One natural sub-module: hazard_fwd_unit, the purely combinational match/forward logic, instantiated once and feeding both fwd_a/fwd_b and the load-use detect.

Test Plan:
- Exec writes r5 (no load), decode reads rs1 = r5 -> fwd_a = 2'b10, no stall; same with r0 -> fwd_a = 2'b00.
- Exec is a load to r7, decode uses rs2 = r7 -> pc_stall/ifid_stall/idex_bubble high for one cycle, next cycle fwd_b = 2'b01, stall_cnt = 1.
- Exec writes FP f3, decode reads integer r3 -> no forward, no stall.
- id_mc = 1, mc_done arrives 5 cycles after mc_go -> 5 stall cycles with idex_stall/exmem_bubble high, RUN on the done cycle, stall_cnt = 5.
- MC_TIMEOUT = 8, mc_done never arrives -> mc_abort pulses in the 8th wait cycle, mc_error = 1 and stays set until reset.
- In MC_WAIT, mem_branch_taken = 1 on the same cycle as mc_done -> flush_ifid/flush_idex = 1, mc_abort pulses, mc_error = 0, flush_cnt = 1, state RUN.
